projection_histogram: RTL and testbench

PROJECTION_HISTOGRAM -- requirements
Module: projection_histogram

---
 rtl/projection_histogram.sv | 177 +++++++++++++++++
 tb/tb_projection_histogram.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/projection_histogram.sv
// Projection histogram of a binary image.
// Counts set pixels per column (x bins) and per row (y bins) over a
// column-major pixel stream, tracks the peak bin of each axis, and
// offers serial readout and a sequential clear of both bin sets.
//
// state  | meaning
// IDLE   | waiting for start or clear
// ACCUM  | accepting pixels of one frame
// READY  | frame done; read, clear or start another frame
// READ   | streaming x and y bins out concurrently
// CLEAR  | zeroing one x and one y bin per cycle
module projection_histogram #(
  parameter  int IMG_W = 240,
  parameter  int IMG_H = 180,
  parameter  int CNT_W = 8,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pixelValid,
  input  logic             pixelIn,
  input  logic             readHistogram,
  input  logic             clearHistogram,
  output logic [CNT_W-1:0] xHistogramOut,
  output logic [XW-1:0]    xIndex,
  output logic             xValid,
  output logic [CNT_W-1:0] yHistogramOut,
  output logic [YW-1:0]    yIndex,
  output logic             yValid,
  output logic [XW-1:0]    peakX,
  output logic [CNT_W-1:0] peakXCount,
  output logic [YW-1:0]    peakY,
  output logic [CNT_W-1:0] peakYCount,
  output logic             overflow,
  output logic             histogramClear,
  output logic             ready
);

  localparam int MAXWH = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW    = $clog2(MAXWH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_READY, S_READ, S_CLEAR} state_t;

  state_t           state, state_nxt;
  logic [XW-1:0]    x_pos;
  logic [YW-1:0]    y_pos;
  logic [CW-1:0]    seq_cnt;
  logic [CNT_W-1:0] xbin [IMG_W];
  logic [CNT_W-1:0] ybin [IMG_H];

  logic             last_pixel, seq_last;
  logic [CNT_W-1:0] x_cur, y_cur, x_new, y_new;
  logic             x_sat, y_sat;
  logic             x_rd, y_rd;

  assign last_pixel = pixelValid && (x_pos == XW'(IMG_W - 1)) && (y_pos == YW'(IMG_H - 1));
  assign seq_last   = (seq_cnt == CW'(MAXWH - 1));

  // Saturating increment values for the bins addressed by the current pixel
  assign x_cur = xbin[x_pos];
  assign y_cur = ybin[y_pos];
  assign x_sat = (x_cur == CNT_MAX);
  assign y_sat = (y_cur == CNT_MAX);
  assign x_new = x_sat ? x_cur : x_cur + 1'b1;
  assign y_new = y_sat ? y_cur : y_cur + 1'b1;

  // Readout lanes; the shorter axis goes quiet once its bins are exhausted
  assign x_rd          = (state == S_READ) && (seq_cnt < CW'(IMG_W));
  assign y_rd          = (state == S_READ) && (seq_cnt < CW'(IMG_H));
  assign xValid        = x_rd;
  assign yValid        = y_rd;
  assign xIndex        = x_rd ? seq_cnt[XW-1:0] : '0;
  assign yIndex        = y_rd ? seq_cnt[YW-1:0] : '0;
  assign xHistogramOut = x_rd ? xbin[seq_cnt[XW-1:0]] : '0;
  assign yHistogramOut = y_rd ? ybin[seq_cnt[YW-1:0]] : '0;
  assign ready         = (state == S_IDLE) || (state == S_READY);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; clear has priority over the other commands
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clearHistogram)  state_nxt = S_CLEAR;
        else if (start)      state_nxt = S_ACCUM;
      end
      S_ACCUM: if (last_pixel) state_nxt = S_READY;
      S_READY: begin
        if (clearHistogram)     state_nxt = S_CLEAR;
        else if (readHistogram) state_nxt = S_READ;
        else if (start)         state_nxt = S_ACCUM;
      end
      S_READ:  if (seq_last) state_nxt = S_READY;
      S_CLEAR: if (seq_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bins, position, peaks, overflow and the readout/clear sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IMG_W; i++) xbin[i] <= '0;
      for (int i = 0; i < IMG_H; i++) ybin[i] <= '0;
      x_pos          <= '0;
      y_pos          <= '0;
      seq_cnt        <= '0;
      peakX          <= '0;
      peakXCount     <= '0;
      peakY          <= '0;
      peakYCount     <= '0;
      overflow       <= 1'b0;
      histogramClear <= 1'b0;
    end else begin
      histogramClear <= 1'b0;
      if (state == S_READ || state == S_CLEAR) seq_cnt <= seq_cnt + 1'b1;
      else                                     seq_cnt <= '0;

      case (state)
        S_IDLE, S_READY: begin
          if (state_nxt == S_ACCUM) begin
            x_pos      <= '0;
            y_pos      <= '0;
            peakX      <= '0;
            peakXCount <= '0;
            peakY      <= '0;
            peakYCount <= '0;
          end
        end
        S_ACCUM: begin
          if (pixelValid) begin
            if (y_pos == YW'(IMG_H - 1)) begin
              y_pos <= '0;
              x_pos <= (x_pos == XW'(IMG_W - 1)) ? '0 : x_pos + 1'b1;
            end else begin
              y_pos <= y_pos + 1'b1;
            end
            if (pixelIn) begin
              xbin[x_pos] <= x_new;
              ybin[y_pos] <= y_new;
              if (x_sat || y_sat) overflow <= 1'b1;
              if (x_new > peakXCount) begin
                peakX      <= x_pos;
                peakXCount <= x_new;
              end
              if (y_new > peakYCount) begin
                peakY      <= y_pos;
                peakYCount <= y_new;
              end
            end
          end
        end
        S_CLEAR: begin
          if (seq_cnt < CW'(IMG_W)) xbin[seq_cnt[XW-1:0]] <= '0;
          if (seq_cnt < CW'(IMG_H)) ybin[seq_cnt[YW-1:0]] <= '0;
          if (seq_last) begin
            histogramClear <= 1'b1;
            overflow       <= 1'b0;
            peakX          <= '0;
            peakXCount     <= '0;
            peakY          <= '0;
            peakYCount     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_projection_histogram.sv
// Directed bench for projection_histogram on a 4x3 image. Two instances
// share stimulus: dut (8-bit bins) and dut_s (2-bit bins, saturating).
module tb_projection_histogram;

  logic clk = 1'b0;
  logic reset, start, pixelValid, pixelIn, readHistogram, clearHistogram;

  logic [7:0] xh, yh, pxc, pyc;
  logic [1:0] xi, yi, px, py;
  logic       xv, yv, ovf, hclr, rdy;

  logic [1:0] xh_s, yh_s, pxc_s, pyc_s;
  logic [1:0] xi_s, yi_s, px_s, py_s;
  logic       xv_s, yv_s, ovf_s, hclr_s, rdy_s;

  int checks = 0;
  int errors = 0;

  int gx[4], gxv[4], gxi[4], gy[4], gyv[4], gyi[4], gx_s[4], gy_s[4];

  typedef struct packed {
    logic [11:0]     pix;
    logic            gaps;
    logic [3:0][7:0] ex;
    logic [2:0][7:0] ey;
    logic [7:0]      pxi, pxc, pyi, pyc;
  } vec_t;

  vec_t tv[5];

  projection_histogram #(.IMG_W(4), .IMG_H(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pixelValid(pixelValid), .pixelIn(pixelIn),
    .readHistogram(readHistogram), .clearHistogram(clearHistogram),
    .xHistogramOut(xh), .xIndex(xi), .xValid(xv),
    .yHistogramOut(yh), .yIndex(yi), .yValid(yv),
    .peakX(px), .peakXCount(pxc), .peakY(py), .peakYCount(pyc),
    .overflow(ovf), .histogramClear(hclr), .ready(rdy));

  projection_histogram #(.IMG_W(4), .IMG_H(3), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .start(start), .pixelValid(pixelValid), .pixelIn(pixelIn),
    .readHistogram(readHistogram), .clearHistogram(clearHistogram),
    .xHistogramOut(xh_s), .xIndex(xi_s), .xValid(xv_s),
    .yHistogramOut(yh_s), .yIndex(yi_s), .yValid(yv_s),
    .peakX(px_s), .peakXCount(pxc_s), .peakY(py_s), .peakYCount(pyc_s),
    .overflow(ovf_s), .histogramClear(hclr_s), .ready(rdy_s));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Pulse clear, expect histogramClear five edges after the pulse edge
  task automatic do_clear(input string tag);
    int n;
    clearHistogram = 1'b1;
    tick();
    clearHistogram = 1'b0;
    n = 1;
    while (!hclr && n < 20) begin
      tick();
      n++;
    end
    check({tag, " clear latency"}, n, 5);
    check({tag, " clear pulse sat"}, hclr_s, 1);
    check({tag, " overflow cleared"}, ovf, 0);
    check({tag, " overflow cleared sat"}, ovf_s, 0);
    check({tag, " peak cleared"}, {pxc, pyc}, 0);
    tick();
    check({tag, " clear single pulse"}, hclr, 0);
  endtask

  // Column-major frame; optional idle gaps carry pixelIn=1 to prove gating;
  // inject_k places a cycle of ignored commands before pixel inject_k
  task automatic feed_frame(input string tag, input logic [11:0] pix, input logic gaps, input int inject_k);
    for (int k = 0; k < 12; k++) begin
      if (gaps && (k % 2 == 1)) begin
        pixelValid = 1'b0;
        pixelIn    = 1'b1;
        tick();
      end
      if (k == inject_k) begin
        pixelValid     = 1'b0;
        start          = 1'b1;
        readHistogram  = 1'b1;
        clearHistogram = 1'b1;
        tick();
        start          = 1'b0;
        readHistogram  = 1'b0;
        clearHistogram = 1'b0;
        check({tag, " cmds ignored ready"}, rdy, 0);
        check({tag, " cmds ignored xValid"}, xv, 0);
      end
      pixelValid = 1'b1;
      pixelIn    = pix[k];
      if (k == 11) check({tag, " ready low before last"}, rdy, 0);
      tick();
    end
    pixelValid = 1'b0;
    pixelIn    = 1'b0;
    check({tag, " ready after last"}, rdy, 1);
  endtask

  task automatic readout(input string tag);
    readHistogram = 1'b1;
    tick();
    readHistogram = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gx[i] = int'(xh); gxv[i] = int'(xv); gxi[i] = int'(xi);
      gy[i] = int'(yh); gyv[i] = int'(yv); gyi[i] = int'(yi);
      gx_s[i] = int'(xh_s); gy_s[i] = int'(yh_s);
      tick();
    end
    check({tag, " ready after read"}, rdy, 1);
    check({tag, " xValid off after read"}, xv, 0);
  endtask

  task automatic compare_bins(input string tag, input logic [3:0][7:0] ex, input logic [2:0][7:0] ey);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s xbin%0d", tag, i), gx[i], int'(ex[i]));
      check($sformatf("%s xValid%0d", tag, i), gxv[i], 1);
      check($sformatf("%s xIndex%0d", tag, i), gxi[i], i);
      check($sformatf("%s sat xbin%0d", tag, i), gx_s[i], sat3(int'(ex[i])));
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s ybin%0d", tag, i), gy[i], int'(ey[i]));
      check($sformatf("%s yValid%0d", tag, i), gyv[i], 1);
      check($sformatf("%s yIndex%0d", tag, i), gyi[i], i);
      check($sformatf("%s sat ybin%0d", tag, i), gy_s[i], sat3(int'(ey[i])));
    end
    check({tag, " y idle value"}, gy[3], 0);
    check({tag, " y idle valid"}, gyv[3], 0);
  endtask

  initial begin
    int  ovf_exp, n, saw;
    string tag;

    tv[0] = '{pix: 12'hFFF, gaps: 1'b0, ex: {8'd3, 8'd3, 8'd3, 8'd3}, ey: {8'd4, 8'd4, 8'd4},
              pxi: 8'd0, pxc: 8'd3, pyi: 8'd0, pyc: 8'd4};
    tv[1] = '{pix: 12'h080, gaps: 1'b1, ex: {8'd0, 8'd1, 8'd0, 8'd0}, ey: {8'd0, 8'd1, 8'd0},
              pxi: 8'd2, pxc: 8'd1, pyi: 8'd1, pyc: 8'd1};
    tv[2] = '{pix: 12'h000, gaps: 1'b1, ex: {8'd0, 8'd0, 8'd0, 8'd0}, ey: {8'd0, 8'd0, 8'd0},
              pxi: 8'd0, pxc: 8'd0, pyi: 8'd0, pyc: 8'd0};
    tv[3] = '{pix: 12'h838, gaps: 1'b0, ex: {8'd1, 8'd0, 8'd3, 8'd0}, ey: {8'd2, 8'd1, 8'd1},
              pxi: 8'd1, pxc: 8'd3, pyi: 8'd2, pyc: 8'd2};
    tv[4] = '{pix: 12'h664, gaps: 1'b1, ex: {8'd2, 8'd1, 8'd1, 8'd1}, ey: {8'd2, 8'd1, 8'd2},
              pxi: 8'd3, pxc: 8'd2, pyi: 8'd2, pyc: 8'd2};

    reset = 1'b1; start = 1'b0; pixelValid = 1'b0; pixelIn = 1'b0;
    readHistogram = 1'b0; clearHistogram = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("reset ready", rdy, 1);
    check("reset histogramClear", hclr, 0);
    check("reset valid", {xv, yv}, 0);
    check("reset outputs", {xh, yh, xi, yi}, 0);
    check("reset overflow", ovf, 0);
    check("reset peaks", {px, pxc, py, pyc}, 0);

    for (int v = 0; v < 5; v++) begin
      tag = $sformatf("v%0d", v);
      do_clear(tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " accum ready low"}, rdy, 0);
      feed_frame(tag, tv[v].pix, tv[v].gaps, -1);
      check({tag, " peakX"}, px, tv[v].pxi);
      check({tag, " peakXCount"}, pxc, tv[v].pxc);
      check({tag, " peakY"}, py, tv[v].pyi);
      check({tag, " peakYCount"}, pyc, tv[v].pyc);
      check({tag, " overflow"}, ovf, 0);
      ovf_exp = 0;
      for (int i = 0; i < 4; i++) if (tv[v].ex[i] > 3) ovf_exp = 1;
      for (int i = 0; i < 3; i++) if (tv[v].ey[i] > 3) ovf_exp = 1;
      check({tag, " overflow sat"}, ovf_s, ovf_exp);
      readout(tag);
      compare_bins(tag, tv[v].ex, tv[v].ey);
      check({tag, " peakYCount after read"}, pyc, tv[v].pyc);
    end

    // Two frames accumulated, the first with ignored commands mid-frame
    do_clear("mf");
    start = 1'b1; tick(); start = 1'b0;
    feed_frame("mf1", 12'hFFF, 1'b0, 6);
    start = 1'b1; tick(); start = 1'b0;
    check("mf restart ready low", rdy, 0);
    feed_frame("mf2", 12'hFFF, 1'b1, -1);
    check("mf peakX", px, 0);
    check("mf peakXCount", pxc, 6);
    check("mf peakYCount", pyc, 8);
    check("mf overflow sat", ovf_s, 1);
    readout("mf");
    compare_bins("mf", {8'd6, 8'd6, 8'd6, 8'd6}, {8'd8, 8'd8, 8'd8});

    // Reset in the middle of a frame
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pixelValid = 1'b1; pixelIn = 1'b1;
      tick();
    end
    pixelValid = 1'b0;
    reset = 1'b1;
    tick();
    check("rst mid ready", rdy, 1);
    check("rst mid histogramClear", hclr, 0);
    check("rst mid overflow sat", ovf_s, 0);
    check("rst mid peaks", {pxc, pyc}, 0);
    reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    feed_frame("rst", 12'h000, 1'b0, -1);
    readout("rst");
    compare_bins("rst", '0, '0);

    // Read and clear requested together: clear wins, no readout
    readHistogram = 1'b1; clearHistogram = 1'b1;
    tick();
    readHistogram = 1'b0; clearHistogram = 1'b0;
    check("rc ready low", rdy, 0);
    saw = int'(xv);
    n = 1;
    while (!hclr && n < 20) begin
      tick();
      n++;
      if (xv) saw = 1;
    end
    check("rc clear latency", n, 5);
    check("rc xValid never", saw, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
